// File: rtl/pitch_period_meter.sv
// Measures the period of a digitised square wave in clk cycles, averaging
// 2**AVG_LOG2 accepted periods, rejecting short glitch edges and timing out on silence.
module pitch_period_meter #(
    parameter int CNT_W      = 32,
    parameter int AVG_LOG2   = 2,
    parameter int MIN_PERIOD = 20000,
    parameter int MAX_PERIOD = 3200000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             no_signal
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int K_W   = AVG_LOG2 + 1;

    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_PERIOD);
    localparam logic [K_W-1:0]   K_LAST = K_W'((2 ** AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    function automatic logic [CNT_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
        return CNT_W'(sum >> AVG_LOG2);
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               valid_q, valid_d;
    logic               nosig_q, nosig_d;

    logic               sig_p0_q, sig_p1_q, sig_p2_q;
    logic               rise;
    logic [ACC_W-1:0]   acc_sum;

    // Stage p0/p1: two-flop synchroniser; p2: one-cycle delay for edge detect
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sig_p0_q <= 1'b0;
            sig_p1_q <= 1'b0;
            sig_p2_q <= 1'b0;
        end else begin
            sig_p0_q <= sig_in;
            sig_p1_q <= sig_p0_q;
            sig_p2_q <= sig_p1_q;
        end
    end

    assign rise    = sig_p1_q & ~sig_p2_q;
    assign acc_sum = acc_q + ACC_W'(cnt_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        k_d      = k_q;
        period_d = period_q;
        valid_d  = 1'b0;
        nosig_d  = nosig_q;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            k_d     = '0;
            nosig_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt_d   = CNT_W'(1);
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    // An accepted edge takes priority over the timeout on the same cycle
                    if (rise && (cnt_q >= MIN_C)) begin
                        cnt_d = CNT_W'(1);
                        if (k_q == K_LAST) begin
                            period_d = avg_trunc(acc_sum);
                            valid_d  = 1'b1;
                            nosig_d  = 1'b0;
                            acc_d    = '0;
                            k_d      = '0;
                        end else begin
                            acc_d = acc_sum;
                            k_d   = k_q + K_W'(1);
                        end
                    end else if (cnt_q == MAX_C) begin
                        nosig_d = 1'b1;
                        acc_d   = '0;
                        k_d     = '0;
                        cnt_d   = '0;
                        state_d = ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Measurement state and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            nosig_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            nosig_q  <= nosig_d;
        end
    end

    assign period_out   = period_q;
    assign period_valid = valid_q;
    assign no_signal    = nosig_q;

endmodule
